// File: rtl/register_file.sv
// register_file: write-back register file at the crossbar output.
//   Holds 2**ADDRESS_WIDTH registers of DATA_WIDTH bits, written from the
//   crossbar (xb_rf_En / xb_rf_d at ps_rf_wrtA). Three combinational read
//   ports (X, Y operands to the crossbar, Z store data to data memory) and
//   write-tracking status (per-register written mask, saturating write count)
//   for the program sequencer.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (clears array and status)
//   ps_rf_xA/yA/zA read addresses for X, Y and Z ports
//   ps_rf_wrtA     write address
//   xb_rf_En       write strobe
//   xb_rf_d        write data
//   rf_xb_rx/ry    X / Y operand read data (combinational)
//   rf_dm_z        Z store read data (combinational)
//   rf_ps_wrMask   bit i set once register i has been written since reset
//   rf_ps_wrCnt    saturating count of accepted writes since reset
//
// Build option:
//   RF_BYPASS_EN   when defined, a read port whose address matches an active
//                  write shows xb_rf_d in the same cycle (write-through).
//                  When undefined, reads always return stored contents.

module register_file #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDRESS_WIDTH-1:0]      ps_rf_xA,
  input  logic [ADDRESS_WIDTH-1:0]      ps_rf_yA,
  input  logic [ADDRESS_WIDTH-1:0]      ps_rf_zA,
  input  logic [ADDRESS_WIDTH-1:0]      ps_rf_wrtA,
  input  logic                          xb_rf_En,
  input  logic [DATA_WIDTH-1:0]         xb_rf_d,
  output logic [DATA_WIDTH-1:0]         rf_xb_rx,
  output logic [DATA_WIDTH-1:0]         rf_xb_ry,
  output logic [DATA_WIDTH-1:0]         rf_dm_z,
  output logic [(2**ADDRESS_WIDTH)-1:0] rf_ps_wrMask,
  output logic [7:0]                    rf_ps_wrCnt
);

  localparam int unsigned DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      wr_mask;
  logic [CNT_WIDTH-1:0]  wr_cnt;

  // Register array; reset wins over a coincident write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (xb_rf_En) begin
      regs[ps_rf_wrtA] <= xb_rf_d;
    end
  end

  // Written-register mask; rewrites keep the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_mask <= '0;
    end else if (xb_rf_En) begin
      wr_mask[ps_rf_wrtA] <= 1'b1;
    end
  end

  // Accepted-write counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
    end else if (xb_rf_En && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + CNT_WIDTH'(1);
    end
  end

  assign rf_ps_wrMask = wr_mask;
  assign rf_ps_wrCnt  = wr_cnt;

  // Read ports: zero-latency from the array, optionally forwarding the
  // in-flight write so data memory sees fresh store data.
`ifdef RF_BYPASS_EN
  always_comb begin
    rf_xb_rx = regs[ps_rf_xA];
    rf_xb_ry = regs[ps_rf_yA];
    rf_dm_z  = regs[ps_rf_zA];
    if (xb_rf_En && (ps_rf_xA == ps_rf_wrtA)) rf_xb_rx = xb_rf_d;
    if (xb_rf_En && (ps_rf_yA == ps_rf_wrtA)) rf_xb_ry = xb_rf_d;
    if (xb_rf_En && (ps_rf_zA == ps_rf_wrtA)) rf_dm_z  = xb_rf_d;
  end
`else
  always_comb begin
    rf_xb_rx = regs[ps_rf_xA];
    rf_xb_ry = regs[ps_rf_yA];
    rf_dm_z  = regs[ps_rf_zA];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected observations,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_register_file;

  logic        clk;
  logic        reset;
  logic [3:0]  xa, ya, za, wa;
  logic        en;
  logic [15:0] d;
  logic [15:0] rx, ry, z;
  logic [15:0] mask;
  logic [7:0]  cnt;

  register_file #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .ps_rf_xA(xa), .ps_rf_yA(ya), .ps_rf_zA(za), .ps_rf_wrtA(wa),
    .xb_rf_En(en), .xb_rf_d(d),
    .rf_xb_rx(rx), .rf_xb_ry(ry), .rf_dm_z(z),
    .rf_ps_wrMask(mask), .rf_ps_wrCnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] rx, ry, z, mask;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain contents, written flags and an unbounded count.
  logic [15:0] mem [16];
  bit          written [16];
  int          writes;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s.%s: got %0h expected %0h at %0t", name, field, act, expv, $time);
  endtask

  // Monitor: one observation per falling edge when something is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "rx",   32'(rx),   32'(e.rx));
      check(e.name, "ry",   32'(ry),   32'(e.ry));
      check(e.name, "z",    32'(z),    32'(e.z));
      check(e.name, "mask", 32'(mask), 32'(e.mask));
      check(e.name, "cnt",  32'(cnt),  32'(e.cnt));
    end
  end

  function automatic logic [15:0] model_read(input logic [3:0] ra, input bit wen,
                                             input logic [3:0] wad, input logic [15:0] wd);
`ifdef RF_BYPASS_EN
    if (wen && ra == wad) return wd;
`endif
    return mem[ra];
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (written[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      written[i] = 1'b0;
    end
    writes = 0;
  endtask

  // One cycle: drive just after a rising edge (reset asserted/released here,
  // away from any edge), queue the expected view at the next falling edge,
  // then advance the model by what the following rising edge should do.
  task automatic cycle(input string name, input bit rst, input bit wen,
                       input logic [3:0] wad, input logic [15:0] wd,
                       input logic [3:0] rxa, input logic [3:0] rya,
                       input logic [3:0] rza);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; en = wen; wa = wad; d = wd; xa = rxa; ya = rya; za = rza;
    if (rst) model_clear();
    e.name = name;
    if (rst) begin
      e.rx = '0; e.ry = '0; e.z = '0;
    end else begin
      e.rx = model_read(rxa, wen, wad, wd);
      e.ry = model_read(rya, wen, wad, wd);
      e.z  = model_read(rza, wen, wad, wd);
    end
    e.mask = model_mask();
    e.cnt  = 8'((writes > 255) ? 255 : writes);
    exp_q.push_back(e);
    if (!rst && wen) begin
      mem[wad] = wd;
      written[wad] = 1'b1;
      writes++;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wa = '0; d = '0; xa = '0; ya = '0; za = '0;
    model_clear();

    cycle("reset_init", 1, 0, 4'd0, 16'h0, 4'd0, 4'd1, 4'd2);

    // Reset mid-stream clears R3 and status without a clock edge.
    cycle("t1_write", 0, 1, 4'd3, 16'h1234, 4'd3, 4'd3, 4'd3);
    cycle("t1_before", 0, 0, 4'd0, 16'h0, 4'd3, 4'd3, 4'd3);
    cycle("t1_reset", 1, 0, 4'd0, 16'h0, 4'd3, 4'd3, 4'd3);
    cycle("t1_after", 0, 0, 4'd0, 16'h0, 4'd3, 4'd3, 4'd3);

    // Basic write then triple read.
    cycle("t2_write", 0, 1, 4'd5, 16'hA5A5, 4'd0, 4'd0, 4'd0);
    cycle("t2_read", 0, 0, 4'd0, 16'h0, 4'd5, 4'd5, 4'd5);

    // Disabled strobe leaves state untouched.
    for (int i = 0; i < 4; i++)
      cycle("t3_noen", 0, 0, 4'd7, 16'hFFFF, 4'd7, 4'd5, 4'd7);

    // Read-during-write on R2.
    cycle("t4_seed", 0, 1, 4'd2, 16'h0011, 4'd0, 4'd0, 4'd0);
    cycle("t4_rdw", 0, 1, 4'd2, 16'h0022, 4'd2, 4'd2, 4'd2);
    cycle("t4_after", 0, 0, 4'd0, 16'h0, 4'd2, 4'd5, 4'd2);

    // 300 writes cycling all addresses: counter saturates, mask fills.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ra;
      ra = 4'($urandom_range(0, 15));
      cycle("t5_sat", 0, 1, 4'(i % 16), 16'($urandom), ra, 4'(i % 16), 4'(15 - (i % 16)));
    end
    for (int i = 0; i < 16; i++)
      cycle("t5_readback", 0, 0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 4'(i));

    // Reset across an edge with a write pending: the write is lost.
    cycle("t6_seed", 0, 1, 4'd9, 16'h1111, 4'd9, 4'd9, 4'd9);
    cycle("t6_rst_wr", 1, 1, 4'd9, 16'h0BAD, 4'd9, 4'd9, 4'd9);
    cycle("t6_after", 0, 0, 4'd0, 16'h0, 4'd9, 4'd9, 4'd9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 250; i++) begin
      cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom),
            4'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
    end
    cycle("final_idle", 0, 0, 4'd0, 16'h0, 4'd0, 4'd0, 4'd0);

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Register file at the write-back end of the crossbar.
- Consumes the crossbar write strobe and data (xb_rf_En, xb_rf_d) at the address from program sequencer field ps_rf_wrtA.
- Supplies the X/Y operands (rf_xb_rx, rf_xb_ry) that the crossbar forwards to the compute units.
- Also provides a third read port (Z) for data-memory store data, plus write-tracking status for the sequencer.

Parameters:
DATA_WIDTH, 16, width of each register and of every data port
ADDRESS_WIDTH, 4, register address width; depth = 2**ADDRESS_WIDTH (16 registers)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ps_rf_xA  input  ADDRESS_WIDTH  X operand read address
ps_rf_yA  input  ADDRESS_WIDTH  Y operand read address
ps_rf_zA  input  ADDRESS_WIDTH  Z (store-data) read address
ps_rf_wrtA  input  ADDRESS_WIDTH  write address
xb_rf_En  input  1  write strobe from crossbar
xb_rf_d  input  DATA_WIDTH  write data from crossbar
rf_xb_rx  output  DATA_WIDTH  X operand to crossbar
rf_xb_ry  output  DATA_WIDTH  Y operand to crossbar
rf_dm_z  output  DATA_WIDTH  Z store data to data memory
rf_ps_wrMask  output  2**ADDRESS_WIDTH  bit i = 1 once register i has been written since reset
rf_ps_wrCnt  output  8  saturating count of accepted writes since reset

Behaviour:
- Storage: 2**ADDRESS_WIDTH registers of DATA_WIDTH bits.
- Reset, asserted asynchronously:
  - all registers = 0
  - rf_ps_wrMask = 0
  - rf_ps_wrCnt = 0
  - read outputs therefore show 0
- Reset released: state advances only on rising clk edges.
- Write: on rising clk with xb_rf_En=1 and reset=0:
  - reg[ps_rf_wrtA] <= xb_rf_d
  - rf_ps_wrMask[ps_rf_wrtA] <= 1
  - rf_ps_wrCnt <= rf_ps_wrCnt+1, saturating at 8'hFF (never wraps)
  - one write per cycle
  - xb_rf_En=0 leaves all state unchanged.
- Reads: X, Y and Z ports are combinational from the register array, zero latency.
  - Any port may address the same register concurrently.
  - A write is visible on the read ports in the cycle after the write edge.
- Read-during-write, same address, same cycle: behaviour is set by RF_BYPASS_EN (below).
  - The crossbar independently forwards xb_rf_d on X/Y, so default operand correctness does not depend on this block.
- Simultaneous reset and write: reset wins; the write is discarded.
- Reset asserted mid-stream: outputs go to 0 immediately, without waiting for clk.
- Write to an already-written register: the data is overwritten, the mask bit stays 1, and the counter still increments.
- No register is hard-wired. Address 0 is an ordinary register.
- rf_ps_wrMask and rf_ps_wrCnt are registered outputs and update with the write edge.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined: internal write-through on all three read ports.
  - When xb_rf_En=1 and a read address equals ps_rf_wrtA, that port outputs xb_rf_d combinationally in the same cycle.
  - Applies to X, Y and Z, which gives data memory forwarded store data.
- Undefined: read ports always return stored array contents. The old value is shown until the write edge.
- Write, reset, mask and counter behaviour are identical in both builds.

Test Plan:
1. Reset mid-stream: write 16'h1234 to R3, then pulse reset between clock edges -> rf_xb_rx (xA=3) = 0 immediately; wrMask=0; wrCnt=0; after release, R3 reads 0.
2. Basic write/read: En=1, wrtA=5, d=16'hA5A5, one edge; then xA=5, yA=5, zA=5 -> all three outputs 16'hA5A5; wrMask=16'h0020; wrCnt=1.
3. Write disabled: En=0, wrtA=7, d=16'hFFFF, several edges -> R7 reads 0; wrMask bit 7 = 0; wrCnt unchanged.
4. Read-during-write: R2 holds 16'h0011; drive En=1, wrtA=2, d=16'h0022, xA=2 before the edge.
   - Without RF_BYPASS_EN: rx=16'h0011 before the edge, 16'h0022 after.
   - With RF_BYPASS_EN: rx=16'h0022 before the edge.
5. Counter saturation: 300 consecutive writes cycling addresses 0..15 -> wrCnt = 8'hFF; wrMask = 16'hFFFF; each register holds its last value written.
6. Simultaneous reset and write: assert reset across an edge with En=1, wrtA=9, d=16'h0BAD -> R9 = 0; wrCnt = 0.
